// File: rtl/seq_detect_pkg.sv
// Shared types and helpers for the serial pattern detection controller.
// Default widths, FSM state encoding and the pattern-length clamp.
package seq_detect_pkg;

    localparam int DEF_PAT_W = 6;
    localparam int DEF_LEN_W = 3;
    localparam int DEF_CNT_W = 8;
    localparam int DEF_TMO_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    // A length of 0 still compares one bit; lengths beyond the history are capped.
    function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_len);
        if (len == 0)
            return 1;
        if (len > max_len)
            return max_len;
        return len;
    endfunction

endpackage

// File: rtl/seq_match_core.sv
// Bit history, fill counter and masked comparator for one detection run.
// hit is combinational so the completing bit can flag a match in its own cycle.
module seq_match_core #(
    parameter int PAT_W = 6,
    parameter int LEN_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             shift,
    input  logic             in_bit,
    input  logic [LEN_W-1:0] len,
    input  logic [PAT_W-1:0] pattern,
    output logic             hit
);

    logic [PAT_W-1:0] hist;
    logic [LEN_W-1:0] bits_seen;
    logic [PAT_W-1:0] window;
    logic [PAT_W-1:0] mask;

    // Newest bit sits at bit 0, matching the pattern bit ordering.
    assign window = {hist[PAT_W-2:0], in_bit};

    always_comb begin
        mask = '0;
        for (int i = 0; i < PAT_W; i++)
            mask[i] = (i < int'(len));
    end

    // len is never 0 here, so len-1 cannot wrap.
    assign hit = (bits_seen >= len - LEN_W'(1)) && (((window ^ pattern) & mask) == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist      <= '0;
            bits_seen <= '0;
        end else if (clear) begin
            hist      <= '0;
            bits_seen <= '0;
        end else if (shift) begin
            hist <= window;
            if (bits_seen < len)
                bits_seen <= bits_seen + LEN_W'(1);
        end
    end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Run controller for serial pattern detection: config latch, FSM, match and timeout counters.
// in_valid qualifies in_bit each cycle; there is no backpressure, every valid bit is consumed.
module seq_detect_ctrl
    import seq_detect_pkg::*;
#(
    parameter int PAT_W = DEF_PAT_W,
    parameter int LEN_W = DEF_LEN_W,
    parameter int CNT_W = DEF_CNT_W,
    parameter int TMO_W = DEF_TMO_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_overlap,
    input  logic [CNT_W-1:0] cfg_target,
    input  logic [TMO_W-1:0] cfg_timeout,
    input  logic             in_bit,
    input  logic             in_valid,
    output logic             match,
    output logic [CNT_W-1:0] match_cnt,
    output logic             busy,
    output logic             done,
    output logic             timeout_flag,
    output state_t           fsm_state
);

    state_t           state;
    logic [PAT_W-1:0] lat_pattern;
    logic [LEN_W-1:0] lat_len;
    logic             lat_overlap;
    logic [CNT_W-1:0] lat_target;
    logic [TMO_W-1:0] lat_timeout;
    logic [TMO_W-1:0] timer;

    logic             launch;
    logic             active_in;
    logic             hit;
    logic [CNT_W-1:0] cnt_inc;
    logic             target_hit;
    logic             tmo_hit;

    assign fsm_state = state;

    // abort beats start, including in IDLE.
    assign launch     = (state == IDLE) && start && !abort;
    assign active_in  = (state == RUN) && in_valid && !abort;
    assign match      = active_in && hit;
    assign cnt_inc    = (&match_cnt) ? match_cnt : match_cnt + CNT_W'(1);
    assign target_hit = match && (lat_target != '0) && (cnt_inc == lat_target);
    assign tmo_hit    = (lat_timeout != '0) && (timer == lat_timeout - TMO_W'(1));

    seq_match_core #(
        .PAT_W (PAT_W),
        .LEN_W (LEN_W)
    ) u_core (
        .clk     (clk),
        .reset   (reset),
        .clear   (launch || (match && !lat_overlap)),
        .shift   (active_in),
        .in_bit  (in_bit),
        .len     (lat_len),
        .pattern (lat_pattern),
        .hit     (hit)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            lat_pattern  <= '0;
            lat_len      <= LEN_W'(1);
            lat_overlap  <= 1'b0;
            lat_target   <= '0;
            lat_timeout  <= '0;
            timer        <= '0;
            match_cnt    <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            timeout_flag <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (launch) begin
                        lat_pattern  <= cfg_pattern;
                        lat_len      <= LEN_W'(clamp_len(int'(cfg_len), PAT_W));
                        lat_overlap  <= cfg_overlap;
                        lat_target   <= cfg_target;
                        lat_timeout  <= cfg_timeout;
                        timer        <= '0;
                        match_cnt    <= '0;
                        timeout_flag <= 1'b0;
                        busy         <= 1'b1;
                        state        <= ARM;
                    end
                end
                ARM: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        if (match)
                            match_cnt <= cnt_inc;
                        if (timer != '1)
                            timer <= timer + TMO_W'(1);
                        // A target met on the last allowed cycle is a clean finish, not a timeout.
                        if (target_hit) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else if (tmo_hit) begin
                            busy         <= 1'b0;
                            done         <= 1'b1;
                            timeout_flag <= 1'b1;
                            state        <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
